// File: rtl/transfer_arb_pkg.sv
// Shared types and constants for the transfer arbiter.
// The optional XFER timeout is enabled by defining TRANSFER_ARB_TIMEOUT_EN.
package transfer_arb_pkg;

    // Default channel data width
    localparam int DEF_DATA_W = 8;

    // Read data returned on a timed-out transfer; wide enough for any
    // practical DATA_W, the top slices off what it needs
    localparam logic [63:0] ERR_DATA = '1;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        XFER     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

endpackage

// File: rtl/xfer_rr_pick.sv
// Round-robin winner selection: searches upward from last_winner+1
// (wrapping) and returns the first active requester as one-hot and index.
module xfer_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the requesters in priority order; the first one set wins
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_winner) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found           = 1'b1;
                winner_idx      = cand;
                winner_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/transfer_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters a shared
// valid/ready master channel, one transfer at a time.
// Define TRANSFER_ARB_TIMEOUT_EN to abort transfers whose slave does not
// answer within TIMEOUT cycles (rdata forced to all ones, sticky error).
module transfer_arbiter
    import transfer_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      chan_address,
    output logic [DATA_W-1:0]         chan_mdata,
    output logic                      chan_valid,
    input  logic [DATA_W-1:0]         chan_sdata,
    input  logic                      chan_ready,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last_winner;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               tmo_hit;

    xfer_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner_oh   (pick_oh),
        .winner_idx  (pick_idx)
    );

    assign pick_found = |req;
    assign busy       = (state != IDLE);

    // State register; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: chan_ready only matters while in XFER
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_found) state_nxt = GRANT;
            GRANT:    state_nxt = XFER;
            XFER:     if (chan_ready || tmo_hit) state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Grant, channel drive, read capture and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt          <= '0;
            done         <= '0;
            win_idx      <= '0;
            last_winner  <= LAST_RST;
            chan_address <= 1'b0;
            chan_mdata   <= '0;
            chan_valid   <= 1'b0;
            rdata        <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt     <= pick_oh;
                        win_idx <= pick_idx;
                    end
                end
                GRANT: begin
                    // Winner's inputs are latched here; later req changes are ignored
                    chan_address <= req_addr[win_idx];
                    chan_mdata   <= req_wdata[win_idx*DATA_W +: DATA_W];
                    chan_valid   <= 1'b1;
                end
                XFER: begin
                    if (chan_ready) begin
                        rdata      <= chan_sdata;
                        chan_valid <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata      <= ERR_DATA[DATA_W-1:0];
                        chan_valid <= 1'b0;
                    end
                end
                COMPLETE: begin
                    done        <= gnt;
                    gnt         <= '0;
                    last_winner <= win_idx;
                end
                default: ;
            endcase
        end
    end

`ifdef TRANSFER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] xfer_cnt;

    // Fires on the TIMEOUT-th XFER cycle that still has no chan_ready
    assign tmo_hit = (state == XFER) && !chan_ready &&
                     (xfer_cnt == CNT_W'(TIMEOUT - 1));

    // Count cycles spent in XFER, cleared outside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                xfer_cnt <= '0;
        else if (state == XFER) xfer_cnt <= xfer_cnt + 1'b1;
        else                    xfer_cnt <= '0;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          timeout_err <= 1'b0;
        else if (tmo_hit) timeout_err <= 1'b1;
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_transfer_arbiter.sv
// Bench for transfer_arbiter: table of single transfers plus hand-written
// sequences (reset state, all-request rotation, mid-transfer reset,
// timeout or long stall depending on TRANSFER_ARB_TIMEOUT_EN).
module tb_transfer_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rdata;
    logic        chan_address;
    logic [7:0]  chan_mdata;
    logic        chan_valid;
    logic [7:0]  chan_sdata = '0;
    logic        chan_ready = 1'b0;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         idx;
        logic [7:0] mdata;
        logic       addr;
        logic [7:0] rdata;
        logic       terr;
        int         lat;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  sdata;
        int          stall;
        bit          drop;
        bit          early;
        int          idx;
        logic [7:0]  mdata;
        logic        addr_e;
        logic [7:0]  rdata;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    transfer_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .chan_address (chan_address),
        .chan_mdata   (chan_mdata),
        .chan_valid   (chan_valid),
        .chan_sdata   (chan_sdata),
        .chan_ready   (chan_ready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] m, input logic a,
                            input logic [7:0] r, input logic terr, input int lat);
        exp_t e;
        e.idx = idx; e.mdata = m; e.addr = a; e.rdata = r; e.terr = terr; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   gnt, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_valid"}, chan_valid, 0);
        check({tag, "_addr"},  chan_address, 0);
        check({tag, "_mdata"}, chan_mdata, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_terr"},  timeout_err, 0);
    endtask

    // Act as the slave and compare each done pulse against the scoreboard
    task automatic serve(input int n, input int stall, input bit drop, input bit hold_ready);
        int cyc;
        int last_done;
        int got;
        int vcnt;
        logic [7:0] m0;
        logic a0;
        exp_t e;
        cyc = 0; last_done = 0; got = 0; vcnt = 0; m0 = '0; a0 = 1'b0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (drop && gnt != 0) req = '0;
            if (chan_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    m0 = chan_mdata;
                    a0 = chan_address;
                    if (sb.size() > 0) check("gnt_onehot", gnt, 32'd1 << sb[0].idx);
                end else begin
                    check("hold_mdata", chan_mdata, m0);
                    check("hold_addr", chan_address, a0);
                end
                check("busy_xfer", busy, 1);
                chan_ready = hold_ready || (vcnt > stall);
            end
            if (done != 0) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got %0h expected none", done);
                end else begin
                    e = sb.pop_front();
                    check("done", done, 32'd1 << e.idx);
                    check("mdata", m0, e.mdata);
                    check("address", a0, e.addr);
                    check("rdata", rdata, e.rdata);
                    check("timeout_err", timeout_err, e.terr);
                    check("latency", cyc - last_done, e.lat);
                end
                last_done = cyc;
                got++;
                vcnt = 0;
                chan_ready = hold_ready;
                if (got == n) begin
                    req = '0;
                    chan_ready = 1'b0;
                end
            end
        end
        if (got < n) begin
            total++; bad++;
            $display("FAIL serve_bound: got %0d done pulses expected %0d", got, n);
        end
    endtask

    task automatic apply(input vec_t v);
        req = v.req; req_addr = v.addr; req_wdata = v.wdata;
        chan_sdata = v.sdata; chan_ready = v.early;
        push_exp(v.idx, v.mdata, v.addr_e, v.rdata, 1'b0, v.lat);
    endtask

    initial begin
        //            req      addr     wdata          sdata  stall drop early idx mdata  a  rdata  lat
        tbl[0] = '{4'b0001, 4'b0000, 32'h000000a5, 8'h3c, 0,  0, 0, 0, 8'ha5, 1'b0, 8'h3c, 4};
        tbl[1] = '{4'b0110, 4'b0010, 32'h00221100, 8'h5a, 0,  0, 0, 1, 8'h11, 1'b1, 8'h5a, 4};
        tbl[2] = '{4'b0110, 4'b0010, 32'h00221100, 8'h66, 0,  0, 0, 2, 8'h22, 1'b0, 8'h66, 4};
        tbl[3] = '{4'b1001, 4'b1001, 32'hc300000f, 8'h00, 5,  0, 0, 3, 8'hc3, 1'b1, 8'h00, 9};
        tbl[4] = '{4'b0101, 4'b0100, 32'h00770080, 8'h7e, 0,  0, 1, 0, 8'h80, 1'b0, 8'h7e, 4};
        tbl[5] = '{4'b0100, 4'b0100, 32'h00990000, 8'he1, 0,  1, 0, 2, 8'h99, 1'b1, 8'he1, 4};
        tbl[6] = '{4'b1011, 4'b0000, 32'h12345678, 8'h0f, 12, 0, 0, 3, 8'h12, 1'b0, 8'h0f, 16};
        tbl[7] = '{4'b0011, 4'b0011, 32'h12345678, 8'hc4, 1,  0, 0, 0, 8'h78, 1'b1, 8'hc4, 5};

        #1 rst = 1'b1;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            serve(1, tbl[i].stall, tbl[i].drop, tbl[i].early);
        end

        // Mid-transfer reset: slave never answers, reset lands inside XFER
        req = 4'b0001; req_addr = 4'b0001; req_wdata = 32'h000000a5; chan_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", chan_valid, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0; req = '0;
        sb.delete();
        req = 4'b1000; req_addr = 4'b1000; req_wdata = 32'h5d000000; chan_sdata = 8'h21;
        push_exp(3, 8'h5d, 1'b1, 8'h21, 1'b0, 4);
        serve(1, 0, 0, 0);

        // All requesting: rotation 0,1,2,3,0 with one done each
        req = 4'b1111; req_addr = 4'b1010; req_wdata = 32'hd4c3b2a1; chan_sdata = 8'h44;
        push_exp(0, 8'ha1, 1'b0, 8'h44, 1'b0, 4);
        push_exp(1, 8'hb2, 1'b1, 8'h44, 1'b0, 4);
        push_exp(2, 8'hc3, 1'b0, 8'h44, 1'b0, 4);
        push_exp(3, 8'hd4, 1'b1, 8'h44, 1'b0, 4);
        push_exp(0, 8'ha1, 1'b0, 8'h44, 1'b0, 4);
        serve(5, 0, 0, 0);

        // Unresponsive slave (last winner 0, so requester 1 wins)
        req = 4'b0010; req_addr = 4'b0000; req_wdata = 32'h00005500; chan_sdata = 8'h3c;
`ifdef TRANSFER_ARB_TIMEOUT_EN
        push_exp(1, 8'h55, 1'b0, 8'hff, 1'b1, 18);
        serve(1, 1000, 0, 0);
        @(negedge clk);
        check("terr_sticky", timeout_err, 1);
        rst = 1'b1;
        #1 check("terr_cleared", timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;
`else
        push_exp(1, 8'h55, 1'b0, 8'h3c, 1'b0, 44);
        serve(1, 40, 0, 0);
`endif

        sb.delete();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
